// File: rtl/axi_ic_pkg.sv
// Shared types and helpers for the 2-master AXI interconnect arbiters.
package axi_ic_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    WA_IDLE = 2'd0,
    WA_DATA = 2'd1,
    WA_RESP = 2'd2
  } axi_wr_arb_state_e;

  // Index of the master owning a one-hot 2-way grant.
  function automatic logic gnt_idx(input logic [NUM_MASTERS-1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/axi_rr_pick2.sv
// Combinational 2-way picker: a sole requester wins; ties go to the master that
// did not own the bus last (rr_en_i=1) or to master 0 (rr_en_i=0).
module axi_rr_pick2
  import axi_ic_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   last_i,
  input  logic                   rr_en_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  // Winner selection
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11: begin
        if (rr_en_i && !last_i) begin
          gnt_o = 2'b10;
        end else begin
          gnt_o = 2'b01;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_arbiter_w.sv
// Write-path arbiter: grants one master for a whole AW/W/B transaction, with
// round-robin or fixed priority and an optional hold watchdog.
module axi_arbiter_w
  import axi_ic_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int HOLD_MAX = 256
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic s_AWVALID,
  input  logic m_AWREADY,
  input  logic s_WVALID,
  input  logic s_WLAST,
  input  logic m_WREADY,
  input  logic m_BVALID,
  input  logic s_BREADY,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic wr_busy,
  output logic wr_timeout
);

  localparam int              CNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : CNT_MAX;
  localparam logic            WD_EN   = (HOLD_MAX > 0);
  localparam logic            RR_ON   = (RR_EN != 0);

  axi_wr_arb_state_e       state_q, state_d;
  logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    busy_q, busy_d;
  logic                    tmo_q, tmo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0]  req_s, pick_s;
  logic                    aw_hs_s, wlast_hs_s, b_hs_s, wd_hit_s;

  assign req_s      = {m1_AWVALID, m0_AWVALID};
  assign aw_hs_s    = s_AWVALID & m_AWREADY;
  assign wlast_hs_s = s_WVALID & m_WREADY & s_WLAST;
  assign b_hs_s     = m_BVALID & s_BREADY;
  assign wd_hit_s   = WD_EN && (state_q != WA_IDLE) && (cnt_q == CNT_LIM);

  axi_rr_pick2 u_pick (
    .req_i   (req_s),
    .last_i  (last_q),
    .rr_en_i (RR_ON),
    .gnt_o   (pick_s)
  );

  // Next-state, grant, flag and watchdog logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;

    case (state_q)
      WA_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (|req_s) begin
          gnt_d   = pick_s;
          state_d = WA_DATA;
        end else begin
          gnt_d   = 2'b00;
        end
      end
      WA_DATA: begin
        aw_done_d = aw_done_q | aw_hs_s;
        w_done_d  = w_done_q | wlast_hs_s;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if (aw_done_d && w_done_d) begin
          state_d = WA_RESP;
        end else begin
          state_d = WA_DATA;
        end
      end
      WA_RESP: begin
        if (b_hs_s) begin
          state_d   = WA_IDLE;
          gnt_d     = 2'b00;
          last_d    = gnt_idx(gnt_q);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d   = WA_IDLE;
        gnt_d     = 2'b00;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        cnt_d     = {CNT_W{1'b0}};
      end
    endcase

    // A completing B handshake wins over a watchdog hit in the same cycle.
    if (wd_hit_s && !((state_q == WA_RESP) && b_hs_s)) begin
      state_d   = WA_IDLE;
      gnt_d     = 2'b00;
      last_d    = gnt_idx(gnt_q);
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      cnt_d     = {CNT_W{1'b0}};
      tmo_d     = 1'b1;
    end else begin
      tmo_d     = 1'b0;
    end

    busy_d = |gnt_d;
  end

  // State and output registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= WA_IDLE;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m0_wgrnt   = gnt_q[0];
  assign m1_wgrnt   = gnt_q[1];
  assign wr_busy    = busy_q;
  assign wr_timeout = tmo_q;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one bus stimulus.
module tb_axi_arbiter_w;

  logic ACLK, ARESETn;
  logic m0_AWVALID, m1_AWVALID, s_AWVALID, m_AWREADY;
  logic s_WVALID, s_WLAST, m_WREADY, m_BVALID, s_BREADY;
  logic r_g0, r_g1, r_busy, r_to;
  logic f_g0, f_g1, f_busy, f_to;
  logic f_m1_seen = 1'b0;
  int   errors = 0;
  int   checks = 0;

  axi_arbiter_w #(.RR_EN(1), .HOLD_MAX(16)) u_rr (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWVALID(m0_AWVALID), .m1_AWVALID(m1_AWVALID),
    .s_AWVALID(s_AWVALID), .m_AWREADY(m_AWREADY),
    .s_WVALID(s_WVALID), .s_WLAST(s_WLAST), .m_WREADY(m_WREADY),
    .m_BVALID(m_BVALID), .s_BREADY(s_BREADY),
    .m0_wgrnt(r_g0), .m1_wgrnt(r_g1), .wr_busy(r_busy), .wr_timeout(r_to)
  );

  axi_arbiter_w #(.RR_EN(0), .HOLD_MAX(16)) u_fp (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWVALID(m0_AWVALID), .m1_AWVALID(m1_AWVALID),
    .s_AWVALID(s_AWVALID), .m_AWREADY(m_AWREADY),
    .s_WVALID(s_WVALID), .s_WLAST(s_WLAST), .m_WREADY(m_WREADY),
    .m_BVALID(m_BVALID), .s_BREADY(s_BREADY),
    .m0_wgrnt(f_g0), .m1_wgrnt(f_g1), .wr_busy(f_busy), .wr_timeout(f_to)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Grant one-hot/zero invariant on both instances, sampled mid-cycle
  always @(negedge ACLK) begin
    checks++;
    assert (!(r_g0 && r_g1) && !(f_g0 && f_g1)) else begin
      errors++;
      $error("FAIL onehot observed rr=%b%b fp=%b%b expected not 11", r_g1, r_g0, f_g1, f_g0);
    end
    if (f_g1) f_m1_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // One complete write: AW, then beats of W ending in WLAST, then B
  task automatic xfer(input int beats);
    s_AWVALID = 1'b1; m_AWREADY = 1'b1;
    tick();
    s_AWVALID = 1'b0; m_AWREADY = 1'b0;
    chk("xfer_busy_after_aw", r_busy, 1'b1);
    for (int i = 0; i < beats; i++) begin
      s_WVALID = 1'b1; m_WREADY = 1'b1; s_WLAST = (i == beats - 1);
      tick();
    end
    s_WVALID = 1'b0; m_WREADY = 1'b0; s_WLAST = 1'b0;
    chk("xfer_busy_in_resp", r_busy, 1'b1);
    m_BVALID = 1'b1; s_BREADY = 1'b1;
    tick();
    m_BVALID = 1'b0; s_BREADY = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0;
    m0_AWVALID = 1'b1; m1_AWVALID = 1'b0;
    s_AWVALID = 1'b0; m_AWREADY = 1'b0; s_WVALID = 1'b0; s_WLAST = 1'b0;
    m_WREADY = 1'b0; m_BVALID = 1'b0; s_BREADY = 1'b0;

    // 1: reset with m0 requesting
    repeat (3) tick();
    chk("rst_g0", r_g0, 1'b0);
    chk("rst_g1", r_g1, 1'b0);
    chk("rst_busy", r_busy, 1'b0);
    chk("rst_to", r_to, 1'b0);
    ARESETn = 1'b1;
    tick();
    chk("first_g0", r_g0, 1'b1);
    chk("first_g1", r_g1, 1'b0);
    chk("first_busy", r_busy, 1'b1);

    // 2: both requesting, 4-beat bursts, grants m0,m1,m0,m1
    m1_AWVALID = 1'b1;
    xfer(4);
    chk("rr_idle0_g0", r_g0, 1'b0);
    chk("rr_idle0_busy", r_busy, 1'b0);
    tick();
    chk("rr_t2_g1", r_g1, 1'b1);
    chk("rr_t2_g0", r_g0, 1'b0);
    chk("fp_t2_g0", f_g0, 1'b1);
    xfer(4);
    chk("rr_idle1_g1", r_g1, 1'b0);
    tick();
    chk("rr_t3_g0", r_g0, 1'b1);
    xfer(4);
    chk("rr_idle2_g0", r_g0, 1'b0);
    tick();
    chk("rr_t4_g1", r_g1, 1'b1);
    xfer(4);
    chk("rr_idle3_g1", r_g1, 1'b0);

    // 3: W burst with WLAST before the AW handshake
    tick();
    chk("wfirst_g0", r_g0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s_WVALID = 1'b1; m_WREADY = 1'b1; s_WLAST = (i == 1);
      tick();
    end
    s_WVALID = 1'b0; m_WREADY = 1'b0; s_WLAST = 1'b0;
    m_BVALID = 1'b1; s_BREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wfirst_hold_g0", r_g0, 1'b1);
      chk("wfirst_hold_busy", r_busy, 1'b1);
    end
    m_BVALID = 1'b0; s_BREADY = 1'b0;
    s_AWVALID = 1'b1; m_AWREADY = 1'b1;
    tick();
    s_AWVALID = 1'b0; m_AWREADY = 1'b0;
    chk("wfirst_after_aw_g0", r_g0, 1'b1);
    m_BVALID = 1'b1; s_BREADY = 1'b1;
    tick();
    m_BVALID = 1'b0; s_BREADY = 1'b0;
    chk("wfirst_release_g0", r_g0, 1'b0);

    // 4: AW and WLAST handshakes in the same cycle
    tick();
    chk("same_g1", r_g1, 1'b1);
    s_AWVALID = 1'b1; m_AWREADY = 1'b1; s_WVALID = 1'b1; m_WREADY = 1'b1; s_WLAST = 1'b1;
    tick();
    s_AWVALID = 1'b0; m_AWREADY = 1'b0; s_WVALID = 1'b0; m_WREADY = 1'b0; s_WLAST = 1'b0;
    chk("same_resp_g1", r_g1, 1'b1);
    m_BVALID = 1'b1; s_BREADY = 1'b1;
    tick();
    m_BVALID = 1'b0; s_BREADY = 1'b0;
    chk("same_release_g1", r_g1, 1'b0);
    chk("same_release_busy", r_busy, 1'b0);

    // 5: no B ever; watchdog fires 16 cycles after the grant
    tick();
    chk("wd_grant_g0", r_g0, 1'b1);
    chk("wd_grant_to", r_to, 1'b0);
    s_AWVALID = 1'b1; m_AWREADY = 1'b1; s_WVALID = 1'b1; m_WREADY = 1'b1; s_WLAST = 1'b1;
    tick();
    s_AWVALID = 1'b0; m_AWREADY = 1'b0; s_WVALID = 1'b0; m_WREADY = 1'b0; s_WLAST = 1'b0;
    chk("wd_c1_to", r_to, 1'b0);
    for (int k = 2; k <= 15; k++) begin
      tick();
      chk("wd_wait_to", r_to, 1'b0);
      chk("wd_wait_g0", r_g0, 1'b1);
    end
    tick();
    chk("wd_fire_to", r_to, 1'b1);
    chk("wd_fire_g0", r_g0, 1'b0);
    chk("wd_fire_busy", r_busy, 1'b0);
    chk("wd_fire_fp_to", f_to, 1'b1);
    tick();
    chk("wd_pulse_end", r_to, 1'b0);
    chk("wd_next_g1", r_g1, 1'b1);
    chk("wd_next_fp_g0", f_g0, 1'b1);
    xfer(1);

    // 6: continuous contention; fixed priority keeps m0, round-robin alternates
    for (int t = 0; t < 4; t++) begin
      chk("loop_idle_rr", r_busy, 1'b0);
      tick();
      chk("loop_fp_g0", f_g0, 1'b1);
      chk("loop_rr_g0", r_g0, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk("loop_rr_g1", r_g1, (t % 2 == 0) ? 1'b0 : 1'b1);
      xfer(2);
    end
    chk("fp_m1_never", f_m1_seen, 1'b0);

    // Sole requester m1 wins in both modes; then asynchronous reset mid-transaction
    m0_AWVALID = 1'b0;
    tick();
    chk("sole_rr_g1", r_g1, 1'b1);
    chk("sole_fp_g1", f_g1, 1'b1);
    chk("sole_fp_g0", f_g0, 1'b0);
    #2 ARESETn = 1'b0;
    #1;
    chk("async_rst_g1", r_g1, 1'b0);
    chk("async_rst_fp_g1", f_g1, 1'b0);
    chk("async_rst_busy", r_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
